// File: rtl/rob_multi_retire.sv
// Parametrised reorder buffer: one in-order allocation per cycle, NUM_WB out-of-order completions,
// up to RETIRE_WIDTH in-order retirements, flush on mispredict/exception. Option: `define ROB_WB_BYPASS_EN.
module rob_multi_retire #(
    parameter int ENTRIES      = 16,
    parameter int RETIRE_WIDTH = 2,
    parameter int NUM_WB       = 4,
    localparam int IDXW        = $clog2(ENTRIES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alloc_valid,
    input  logic [4:0]                 alloc_dest_reg,
    input  logic                       alloc_wb_en,
    input  logic [31:0]                alloc_pc,
    output logic                       alloc_ready,
    output logic [IDXW-1:0]            alloc_idx,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*IDXW-1:0]     wb_idx,
    input  logic [NUM_WB*32-1:0]       wb_result,
    input  logic [NUM_WB-1:0]          wb_mispred,
    input  logic [NUM_WB-1:0]          wb_exception,
    output logic [RETIRE_WIDTH-1:0]    ret_valid,
    output logic [RETIRE_WIDTH*5-1:0]  ret_dest_reg,
    output logic [RETIRE_WIDTH-1:0]    ret_wb_en,
    output logic [RETIRE_WIDTH*32-1:0] ret_result,
    output logic [RETIRE_WIDTH*32-1:0] ret_pc,
    output logic                       flush_valid,
    output logic [31:0]                flush_pc,
    output logic [IDXW:0]              count
);

    typedef struct packed {
        logic [4:0]  dest_reg;
        logic        wb_en;
        logic [31:0] pc;
        logic        mispred;
        logic        exception;
    } rob_entry_t;

    localparam logic [IDXW:0] ONE = {{IDXW{1'b0}}, 1'b1};

    logic [IDXW:0]           r_head, r_tail;
    logic [ENTRIES-1:0]      r_vld, r_rdy;
    rob_entry_t              r_ent [ENTRIES];
    logic [31:0]             r_res [ENTRIES];

    logic [ENTRIES-1:0]      w_hit, w_hmp, w_hex;
    logic [31:0]             w_hres [ENTRIES];
    logic [ENTRIES-1:0]      w_rdy, w_mp, w_ex;
    logic [31:0]             w_res [ENTRIES];
    logic [IDXW-1:0]         w_sidx [RETIRE_WIDTH];
    logic [RETIRE_WIDTH-1:0] w_ret_valid;
    logic [IDXW:0]           w_nret;
    logic                    w_flush;
    logic [31:0]             w_flush_pc;
    logic                    w_go;
    logic                    w_full;
    logic                    w_alloc;

    assign w_full      = (r_head[IDXW-1:0] == r_tail[IDXW-1:0]) && (r_head[IDXW] != r_tail[IDXW]);
    assign alloc_ready = !w_full && !w_flush;
    assign w_alloc     = alloc_valid && alloc_ready;
    assign alloc_idx   = r_tail[IDXW-1:0];
    assign count       = r_tail - r_head;
    assign ret_valid   = w_ret_valid;
    assign flush_valid = w_flush;
    assign flush_pc    = w_flush_pc;

    // Per-entry writeback decode; ports scanned high to low so the lowest port lands last and wins.
    always_comb begin
        w_hit = '0;
        w_hmp = '0;
        w_hex = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            w_hres[e] = '0;
            for (int p = NUM_WB - 1; p >= 0; p--) begin
                if (wb_valid[p] && (wb_idx[p*IDXW +: IDXW] == IDXW'(e))) begin
                    w_hit[e]  = r_vld[e];
                    w_hres[e] = wb_result[p*32 +: 32];
                    w_hmp[e]  = wb_mispred[p];
                    w_hex[e]  = wb_exception[p];
                end
            end
        end
    end

    // Completion view seen by retire: registered state, optionally overlaid with this cycle's writebacks.
    always_comb begin
        w_rdy = '0;
        w_mp  = '0;
        w_ex  = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            w_rdy[e] = r_rdy[e];
            w_mp[e]  = r_ent[e].mispred;
            w_ex[e]  = r_ent[e].exception;
            w_res[e] = r_res[e];
`ifdef ROB_WB_BYPASS_EN
            if (w_hit[e]) begin
                w_rdy[e] = 1'b1;
                w_mp[e]  = w_hmp[e];
                w_ex[e]  = w_hex[e];
                w_res[e] = w_hres[e];
            end
`endif
        end
    end

    always_comb begin
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            w_sidx[k] = r_head[IDXW-1:0] + IDXW'(k);
        end
    end

    // Single in-order pass; the first not-ready, faulting or mispredicted entry closes the group.
    always_comb begin
        w_ret_valid = '0;
        w_nret      = '0;
        w_flush     = 1'b0;
        w_flush_pc  = '0;
        w_go        = 1'b1;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            if (w_go) begin
                if (r_vld[w_sidx[k]] && w_rdy[w_sidx[k]]) begin
                    if (w_ex[w_sidx[k]]) begin
                        w_go = 1'b0;
                        if (k == 0) begin
                            w_flush    = 1'b1;
                            w_flush_pc = r_ent[w_sidx[k]].pc;
                        end
                    end else begin
                        w_ret_valid[k] = 1'b1;
                        w_nret         = w_nret + ONE;
                        if (w_mp[w_sidx[k]]) begin
                            w_go       = 1'b0;
                            w_flush    = 1'b1;
                            w_flush_pc = r_ent[w_sidx[k]].pc;
                        end
                    end
                end else begin
                    w_go = 1'b0;
                end
            end
        end
    end

    always_comb begin
        ret_dest_reg = '0;
        ret_wb_en    = '0;
        ret_result   = '0;
        ret_pc       = '0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            ret_dest_reg[k*5 +: 5] = r_ent[w_sidx[k]].dest_reg;
            ret_wb_en[k]           = r_ent[w_sidx[k]].wb_en;
            ret_result[k*32 +: 32] = w_res[w_sidx[k]];
            ret_pc[k*32 +: 32]     = r_ent[w_sidx[k]].pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_vld  <= '0;
            r_rdy  <= '0;
        end else if (w_flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_vld  <= '0;
            r_rdy  <= '0;
        end else begin
            r_rdy <= r_rdy | w_hit;
            for (int k = 0; k < RETIRE_WIDTH; k++) begin
                if (w_ret_valid[k]) begin
                    r_vld[w_sidx[k]] <= 1'b0;
                end
            end
            if (w_alloc) begin
                r_vld[r_tail[IDXW-1:0]] <= 1'b1;
                r_rdy[r_tail[IDXW-1:0]] <= 1'b0;
                r_tail                  <= r_tail + ONE;
            end
            r_head <= r_head + w_nret;
        end
    end

    // Payload storage carries no reset; it is only observed through valid/ready.
    for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
        always_ff @(posedge clk) begin
            if (w_alloc && (r_tail[IDXW-1:0] == IDXW'(e))) begin
                r_ent[e] <= '{dest_reg: alloc_dest_reg, wb_en: alloc_wb_en, pc: alloc_pc,
                              mispred: 1'b0, exception: 1'b0};
            end else if (w_hit[e] && !w_flush) begin
                r_ent[e].mispred   <= w_hmp[e];
                r_ent[e].exception <= w_hex[e];
                r_res[e]           <= w_hres[e];
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_retire.sv
// Self-checking bench for rob_multi_retire (default build, no writeback bypass): directed scenarios
// plus randomized traffic against a queue-based program-order model.
module tb_rob_multi_retire;
    localparam int ENTRIES = 16;
    localparam int RW      = 2;
    localparam int NWB     = 4;
    localparam int IDXW    = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  alloc_valid;
    logic [4:0]            alloc_dest_reg;
    logic                  alloc_wb_en;
    logic [31:0]           alloc_pc;
    logic                  alloc_ready;
    logic [IDXW-1:0]       alloc_idx;
    logic [NWB-1:0]        wb_valid;
    logic [NWB*IDXW-1:0]   wb_idx;
    logic [NWB*32-1:0]     wb_result;
    logic [NWB-1:0]        wb_mispred;
    logic [NWB-1:0]        wb_exception;
    logic [RW-1:0]         ret_valid;
    logic [RW*5-1:0]       ret_dest_reg;
    logic [RW-1:0]         ret_wb_en;
    logic [RW*32-1:0]      ret_result;
    logic [RW*32-1:0]      ret_pc;
    logic                  flush_valid;
    logic [31:0]           flush_pc;
    logic [IDXW:0]         count;

    int tot = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rob_multi_retire #(.ENTRIES(ENTRIES), .RETIRE_WIDTH(RW), .NUM_WB(NWB)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_dest_reg(alloc_dest_reg), .alloc_wb_en(alloc_wb_en),
        .alloc_pc(alloc_pc), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_result(wb_result),
        .wb_mispred(wb_mispred), .wb_exception(wb_exception),
        .ret_valid(ret_valid), .ret_dest_reg(ret_dest_reg), .ret_wb_en(ret_wb_en),
        .ret_result(ret_result), .ret_pc(ret_pc),
        .flush_valid(flush_valid), .flush_pc(flush_pc), .count(count)
    );

    // Reference model: occupied entries in program order.
    typedef struct {
        int          idx;
        logic [4:0]  dest;
        logic        wben;
        logic [31:0] pc;
        bit          rdy;
        logic [31:0] res;
        bit          mp;
        bit          ex;
    } ment_t;

    ment_t           mq[$];
    int              mtail = 0;
    logic [RW-1:0]   exp_rv;
    logic            exp_fl;
    logic [31:0]     exp_fpc;
    int              exp_nret;
    logic [IDXW:0]   exp_cnt;
    logic [IDXW-1:0] exp_aidx;
    logic            exp_ar;
    logic [31:0]     exp_pc   [RW];
    logic [31:0]     exp_res  [RW];
    logic [4:0]      exp_dest [RW];
    logic            exp_wben [RW];

    task automatic model_eval();
        exp_rv   = '0;
        exp_fl   = 1'b0;
        exp_fpc  = '0;
        exp_nret = 0;
        for (int k = 0; k < RW && k < mq.size(); k++) begin
            if (!mq[k].rdy) break;
            if (mq[k].ex) begin
                if (k == 0) begin
                    exp_fl  = 1'b1;
                    exp_fpc = mq[k].pc;
                end
                break;
            end
            exp_rv[k]   = 1'b1;
            exp_pc[k]   = mq[k].pc;
            exp_res[k]  = mq[k].res;
            exp_dest[k] = mq[k].dest;
            exp_wben[k] = mq[k].wben;
            exp_nret++;
            if (mq[k].mp) begin
                exp_fl  = 1'b1;
                exp_fpc = mq[k].pc;
                break;
            end
        end
        exp_cnt  = (IDXW+1)'(mq.size());
        exp_aidx = IDXW'(mtail);
        exp_ar   = (mq.size() < ENTRIES) && !exp_fl;
    endtask

    task automatic model_commit();
        ment_t t;
        if (exp_fl) begin
            mq.delete();
            mtail = 0;
            return;
        end
        for (int p = NWB - 1; p >= 0; p--) begin
            if (wb_valid[p]) begin
                for (int q = 0; q < mq.size(); q++) begin
                    if (mq[q].idx == int'(wb_idx[p*IDXW +: IDXW])) begin
                        t     = mq[q];
                        t.rdy = 1'b1;
                        t.res = wb_result[p*32 +: 32];
                        t.mp  = wb_mispred[p];
                        t.ex  = wb_exception[p];
                        mq[q] = t;
                    end
                end
            end
        end
        for (int k = 0; k < exp_nret; k++) void'(mq.pop_front());
        if (alloc_valid && exp_ar) begin
            t = '{idx: mtail, dest: alloc_dest_reg, wben: alloc_wb_en, pc: alloc_pc,
                  rdy: 1'b0, res: '0, mp: 1'b0, ex: 1'b0};
            mq.push_back(t);
            mtail = (mtail + 1) % ENTRIES;
        end
    endtask

    task automatic idle();
        alloc_valid    = 1'b0;
        alloc_dest_reg = '0;
        alloc_wb_en    = 1'b0;
        alloc_pc       = '0;
        wb_valid       = '0;
        wb_idx         = '0;
        wb_result      = '0;
        wb_mispred     = '0;
        wb_exception   = '0;
    endtask

    task automatic set_alloc(input logic [4:0] dest, input logic wben, input logic [31:0] pc);
        alloc_valid    = 1'b1;
        alloc_dest_reg = dest;
        alloc_wb_en    = wben;
        alloc_pc       = pc;
    endtask

    task automatic set_wb(input int p, input int idx, input logic [31:0] res, input logic mp, input logic ex);
        wb_valid[p]             = 1'b1;
        wb_idx[p*IDXW +: IDXW]  = IDXW'(idx);
        wb_result[p*32 +: 32]   = res;
        wb_mispred[p]           = mp;
        wb_exception[p]         = ex;
    endtask

    task automatic tick();
        model_eval();
        model_commit();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        mq.delete();
        mtail = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        mq.delete();
        mtail = 0;
        #1;
        tot++;
        if (ret_valid !== '0 || flush_valid !== 1'b0 || flush_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_retire got rv=%b fl=%b fpc=%h want rv=0 fl=0 fpc=0", ret_valid, flush_valid, flush_pc);
        end
        tot++;
        if (count !== '0 || alloc_idx !== '0 || alloc_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_alloc got cnt=%0d idx=%0d rdy=%b want cnt=0 idx=0 rdy=1", count, alloc_idx, alloc_ready);
        end
        do_reset();
    endtask

    task automatic test_fill();
        do_reset();
        for (int k = 0; k < ENTRIES; k++) begin
            set_alloc(5'(k), 1'b1, 32'h400 + 32'(4 * k));
            #1;
            tot++;
            if (alloc_idx !== IDXW'(k) || alloc_ready !== 1'b1) begin
                bad++;
                $display("FAIL fill_idx k=%0d got idx=%0d rdy=%b want idx=%0d rdy=1", k, alloc_idx, alloc_ready, k);
            end
            tick();
        end
        set_alloc(5'd31, 1'b1, 32'hdead0000);
        #1;
        tot++;
        if (alloc_ready !== 1'b0 || count !== 5'd16) begin
            bad++;
            $display("FAIL fill_full got rdy=%b cnt=%0d want rdy=0 cnt=16", alloc_ready, count);
        end
        tick();
        tot++;
        if (count !== 5'd16 || alloc_idx !== 4'd0 || ret_valid !== 2'b00) begin
            bad++;
            $display("FAIL fill_ignored got cnt=%0d idx=%0d rv=%b want cnt=16 idx=0 rv=00", count, alloc_idx, ret_valid);
        end
        rst_n = 1'b0;
        #1;
        tot++;
        if (count !== '0 || alloc_ready !== 1'b1 || ret_valid !== '0) begin
            bad++;
            $display("FAIL midop_reset got cnt=%0d rdy=%b rv=%b want cnt=0 rdy=1 rv=00", count, alloc_ready, ret_valid);
        end
        do_reset();
    endtask

    task automatic test_ooo_retire();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_alloc(5'(k + 1), 1'b1, 32'h10 + 32'(4 * k));
            tick();
        end
        set_wb(0, 3, 32'h33, 1'b0, 1'b0);
        set_wb(1, 1, 32'h11, 1'b0, 1'b0);
        tick();
        set_wb(0, 0, 32'hAA, 1'b0, 1'b0);
        #1;
        tot++;
        if (ret_valid !== 2'b00) begin
            bad++;
            $display("FAIL ooo_wait_head got rv=%b want 00", ret_valid);
        end
        tick();
        tot++;
        if (ret_valid !== 2'b11 || ret_result !== {32'h11, 32'hAA} || ret_pc !== {32'h14, 32'h10}) begin
            bad++;
            $display("FAIL ooo_ret01 got rv=%b res=%h pc=%h want rv=11 res=00000011000000aa pc=0000001400000010",
                     ret_valid, ret_result, ret_pc);
        end
        tick();
        set_wb(2, 2, 32'h22, 1'b0, 1'b0);
        #1;
        tot++;
        if (ret_valid !== 2'b00 || count !== 5'd2) begin
            bad++;
            $display("FAIL ooo_wait_2 got rv=%b cnt=%0d want rv=00 cnt=2", ret_valid, count);
        end
        tick();
        tot++;
        if (ret_valid !== 2'b11 || ret_result !== {32'h33, 32'h22} || ret_dest_reg !== {5'd4, 5'd3}) begin
            bad++;
            $display("FAIL ooo_ret23 got rv=%b res=%h dst=%h want rv=11 res=0000003300000022 dst=083", ret_valid, ret_result, ret_dest_reg);
        end
        tick();
        tot++;
        if (count !== '0) begin
            bad++;
            $display("FAIL ooo_empty got cnt=%0d want 0", count);
        end
    endtask

    task automatic test_mispred();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_alloc(5'(k), 1'b1, 32'h100 + 32'(4 * k));
            tick();
        end
        set_wb(0, 0, 32'h55, 1'b1, 1'b0);
        set_wb(1, 1, 32'h66, 1'b0, 1'b0);
        tick();
        tot++;
        if (ret_valid !== 2'b01 || flush_valid !== 1'b1 || flush_pc !== 32'h100 || alloc_ready !== 1'b0) begin
            bad++;
            $display("FAIL mispred_flush got rv=%b fl=%b fpc=%h rdy=%b want rv=01 fl=1 fpc=100 rdy=0",
                     ret_valid, flush_valid, flush_pc, alloc_ready);
        end
        tick();
        tot++;
        if (count !== '0 || alloc_idx !== '0 || flush_valid !== 1'b0 || ret_valid !== 2'b00) begin
            bad++;
            $display("FAIL mispred_after got cnt=%0d idx=%0d fl=%b rv=%b want cnt=0 idx=0 fl=0 rv=00",
                     count, alloc_idx, flush_valid, ret_valid);
        end
    endtask

    task automatic test_exception();
        do_reset();
        set_alloc(5'd7, 1'b1, 32'h200);
        tick();
        set_alloc(5'd8, 1'b1, 32'h204);
        tick();
        set_wb(0, 1, 32'h77, 1'b0, 1'b1);
        set_wb(1, 0, 32'h88, 1'b0, 1'b0);
        tick();
        tot++;
        if (ret_valid !== 2'b01 || flush_valid !== 1'b0 || ret_pc[31:0] !== 32'h200) begin
            bad++;
            $display("FAIL exc_slot1 got rv=%b fl=%b pc0=%h want rv=01 fl=0 pc0=200", ret_valid, flush_valid, ret_pc[31:0]);
        end
        tick();
        tot++;
        if (ret_valid !== 2'b00 || flush_valid !== 1'b1 || flush_pc !== 32'h204) begin
            bad++;
            $display("FAIL exc_head got rv=%b fl=%b fpc=%h want rv=00 fl=1 fpc=204", ret_valid, flush_valid, flush_pc);
        end
        tick();
        tot++;
        if (count !== '0 || flush_valid !== 1'b0) begin
            bad++;
            $display("FAIL exc_after got cnt=%0d fl=%b want cnt=0 fl=0", count, flush_valid);
        end
    endtask

    task automatic test_wrap();
        int seq;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            set_alloc(5'(k), 1'b0, 32'h1000 + 32'(4 * k));
            tick();
        end
        seq = 0;
        for (int c = 0; c < 30 && seq < 14; c++) begin
            if (c < 4) begin
                for (int p = 0; p < NWB; p++) begin
                    if (c * 4 + p < 14) set_wb(p, c * 4 + p, 32'(c * 4 + p), 1'b0, 1'b0);
                end
            end
            #1;
            for (int k = 0; k < RW; k++) begin
                if (ret_valid[k]) begin
                    tot++;
                    if (ret_pc[k*32 +: 32] !== 32'h1000 + 32'(4 * seq)) begin
                        bad++;
                        $display("FAIL wrap_order1 seq=%0d got pc=%h want %h", seq, ret_pc[k*32 +: 32], 32'h1000 + 32'(4 * seq));
                    end
                    seq++;
                end
            end
            tick();
        end
        tot++;
        if (seq != 14 || count !== '0) begin
            bad++;
            $display("FAIL wrap_drain1 got retired=%0d cnt=%0d want 14 and 0", seq, count);
        end
        for (int k = 0; k < 4; k++) begin
            set_alloc(5'(20 + k), 1'b1, 32'h2000 + 32'(4 * k));
            #1;
            tot++;
            if (alloc_idx !== IDXW'((14 + k) % ENTRIES)) begin
                bad++;
                $display("FAIL wrap_idx k=%0d got idx=%0d want %0d", k, alloc_idx, (14 + k) % ENTRIES);
            end
            tick();
        end
        for (int p = 0; p < NWB; p++) set_wb(p, (14 + p) % ENTRIES, 32'hC0 + 32'(p), 1'b0, 1'b0);
        seq = 0;
        for (int c = 0; c < 10 && seq < 4; c++) begin
            #1;
            for (int k = 0; k < RW; k++) begin
                if (ret_valid[k]) begin
                    tot++;
                    if (ret_pc[k*32 +: 32] !== 32'h2000 + 32'(4 * seq) || ret_result[k*32 +: 32] !== 32'hC0 + 32'(seq)) begin
                        bad++;
                        $display("FAIL wrap_order2 seq=%0d got pc=%h res=%h want pc=%h res=%h", seq,
                                 ret_pc[k*32 +: 32], ret_result[k*32 +: 32], 32'h2000 + 32'(4 * seq), 32'hC0 + 32'(seq));
                    end
                    seq++;
                end
            end
            tick();
        end
        tot++;
        if (seq != 4) begin
            bad++;
            $display("FAIL wrap_drain2 got retired=%0d want 4", seq);
        end
    endtask

    task automatic test_same_idx();
        bit found;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_alloc(5'(k), 1'b1, 32'h3000 + 32'(4 * k));
            tick();
        end
        found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            if (c == 0) begin
                for (int p = 0; p < NWB; p++) set_wb(p, p, 32'(p), 1'b0, 1'b0);
            end else if (c == 1) begin
                set_wb(0, 5, 32'hA, 1'b0, 1'b0);
                set_wb(1, 4, 32'h4, 1'b0, 1'b0);
                set_wb(2, 5, 32'hB, 1'b0, 1'b0);
            end
            #1;
            for (int k = 0; k < RW; k++) begin
                if (ret_valid[k] && ret_pc[k*32 +: 32] == 32'h3014) begin
                    found = 1'b1;
                    tot++;
                    if (ret_result[k*32 +: 32] !== 32'hA) begin
                        bad++;
                        $display("FAIL same_idx_result got %h want 0000000a", ret_result[k*32 +: 32]);
                    end
                end
            end
            tick();
        end
        tot++;
        if (!found) begin
            bad++;
            $display("FAIL same_idx_timeout got no retire of idx5 want retire within 12 cycles");
        end
    endtask

    task automatic test_random();
        int idx;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 9) < 7) set_alloc(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
            for (int p = 0; p < NWB; p++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if (mq.size() > 0 && $urandom_range(0, 4) != 0) idx = mq[$urandom_range(0, mq.size() - 1)].idx;
                    else idx = $urandom_range(0, ENTRIES - 1);
                    set_wb(p, idx, $urandom, 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 29) == 0));
                end
            end
            #1;
            model_eval();
            tot++;
            if (ret_valid !== exp_rv || flush_valid !== exp_fl || flush_pc !== exp_fpc) begin
                bad++;
                $display("FAIL rnd_retire n=%0d got rv=%b fl=%b fpc=%h want rv=%b fl=%b fpc=%h",
                         n, ret_valid, flush_valid, flush_pc, exp_rv, exp_fl, exp_fpc);
            end
            tot++;
            if (count !== exp_cnt || alloc_idx !== exp_aidx || alloc_ready !== exp_ar) begin
                bad++;
                $display("FAIL rnd_alloc n=%0d got cnt=%0d idx=%0d rdy=%b want cnt=%0d idx=%0d rdy=%b",
                         n, count, alloc_idx, alloc_ready, exp_cnt, exp_aidx, exp_ar);
            end
            for (int k = 0; k < RW; k++) begin
                if (exp_rv[k]) begin
                    tot++;
                    if (ret_pc[k*32 +: 32] !== exp_pc[k] || ret_result[k*32 +: 32] !== exp_res[k] ||
                        ret_dest_reg[k*5 +: 5] !== exp_dest[k] || ret_wb_en[k] !== exp_wben[k]) begin
                        bad++;
                        $display("FAIL rnd_slot n=%0d k=%0d got pc=%h res=%h dst=%0d we=%b want pc=%h res=%h dst=%0d we=%b",
                                 n, k, ret_pc[k*32 +: 32], ret_result[k*32 +: 32], ret_dest_reg[k*5 +: 5], ret_wb_en[k],
                                 exp_pc[k], exp_res[k], exp_dest[k], exp_wben[k]);
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_fill();
        test_ooo_retire();
        test_mispred();
        test_exception();
        test_wrap();
        test_same_idx();
        test_random();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
